des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Iterative DES key schedule that generates the sixteen 48-bit round keys, one per step, feeding the `i_key` input of `feistel_function`. It loads a 64-bit key, applies PC-1, and then rotates the C/D halves on each advance request. Each round key is presented as PC-2 of the current C/D state. It supports encryption order (K1→K16) and decryption order (K16→K1) and is driven by the round controller that also drives `feistel_function`'s `i_data`.

## Interface
- No parameters; all widths fixed by FIPS 46-3.
- i_clk  input  1  sole clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_load  input  1  single-cycle strobe; latch `i_key` and `i_decrypt` and start a schedule.
- i_key  input  64  DES key; `i_key[63]` = DES bit 1. Parity bits (`i_key[56]`, `[48]`, …, `[0]`) are ignored.
- i_decrypt  input  1  0 = K1 first, 1 = K16 first; sampled only when `i_load`=1.
- i_next  input  1  advance to the next round key; honoured only when `o_valid`=1.
- o_round_key  output  48  current round key; `o_round_key[47]` = DES subkey bit 1.
- o_round  output  4  index of the presented key minus 1 (K1 → 0, K16 → 15).
- o_valid  output  1  `o_round_key`/`o_round` meaningful.
- o_done  output  1  one-cycle pulse after the final key has been consumed.

## Operation
- State registers:
  - C[27:0], D[27:0]
  - round[3:0]
  - dir (latched `i_decrypt`)
  - valid
  - done
- FSM states:
  - IDLE (valid=0)
  - ACTIVE (valid=1)
- Load (any state):
  - {C,D} ← PC-1(`i_key`), then:
  - encrypt: rotate C and D left by 1 (giving K1 state); round ← 0.
  - decrypt: no rotation (the 28-bit total rotation is the identity, giving K16 state); round ← 15.
  - dir ← `i_decrypt`; go to ACTIVE.
- Shift schedule s[r] for key Kr, r=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Advance in ACTIVE with `i_next`=1 and `i_load`=0:
  - encrypt, presenting Kr (r<16): rotate C and D left by s[r+1]; round ← round+1.
  - decrypt, presenting Kr (r>1): rotate C and D right by s[r]; round ← round−1.
  - final key (encrypt K16 or decrypt K1): go to IDLE, valid←0, done←1. C/D and round hold.
- `o_round_key` = PC-2({C,D}); combinational from registers, no extra register stage.
- C and D rotate independently as 28-bit rings; no bits cross between halves.
- Simultaneous events:
  - `i_load` and `i_next` both 1: load wins; the schedule restarts and done stays 0.
  - `i_load` in ACTIVE mid-schedule: clean restart with the new key and direction.
  - `i_next` in IDLE: ignored, no state change.
  - `i_decrypt` changes while ACTIVE: no effect.
- Reset: C=D=0, round=0, dir=0, valid=0, done=0, giving `o_round_key`=0, `o_round`=0, `o_valid`=0, `o_done`=0. Reset overrides load and next.

## Timing
- Load at edge N: K1 (or K16) is on `o_round_key` with `o_valid`=1 after edge N.
- One key per cycle at full rate: `i_next` held high steps 16 keys in 16 consecutive cycles.
- Consumer usage: the consumer feeds `o_round_key` into `feistel_function` and latches its result in the same cycle it asserts `i_next`.
- Final step: `i_next` accepted on the last key at edge M → after M, `o_valid`=0 and `o_done`=1 for one cycle. `o_done` clears after M+1 unless re-triggered.
- Minimum period from load to `o_done`: 17 cycles (load, then 16 `i_next` cycles).
- Reset asserted mid-schedule: all outputs are at reset values after that edge.

## Test plan
- Encrypt, key 0x133457799BBCDFF1:
  - load → `o_round_key`=0x1B02EFFC7072, `o_round`=0.
  - `i_next` → 0x79AED9DBC9E5, `o_round`=1.
  - 14 more `i_next` → 0xCB3D8B0E17F5, `o_round`=15.
  - one more `i_next` → `o_done` pulses 1 cycle, `o_valid`=0.
- Decrypt, same key:
  - load with `i_decrypt`=1 → 0xCB3D8B0E17F5, `o_round`=15.
  - 15 `i_next` → 0x1B02EFFC7072, `o_round`=0.
  - the full sequence is the exact reverse of the encrypt capture.
- Parity independence: load 0x133457799BBCDFF1 XOR 0x0101010101010101 → key sequence identical to the first scenario.
- Stall and ignore:
  - `i_next` gapped randomly: keys advance only on `i_next` cycles.
  - `i_next` pulses in IDLE: no change to any output.
- Restart: `i_load` with a new key at round 7, with `i_next` also high → K1 of the new key next cycle, `o_round`=0, no `o_done`.
- Reset: `i_rst` at round 9 → all outputs 0 the next cycle; a subsequent load behaves as in the first scenario.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on load, per-round C/D rotation, PC-2 output.
// Produces K1..K16 (encrypt) or K16..K1 (decrypt), one key per accepted i_next.
module des_key_schedule (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic        i_next,
  output logic [47:0] o_round_key,
  output logic [3:0]  o_round,
  output logic        o_valid,
  output logic        o_done,
  output logic        o_state
);

  // Handshake: a key is offered while o_valid=1; it is consumed on any rising
  // edge where i_next=1 and o_valid=1. i_load restarts unconditionally.

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

  // DES bit positions (1 = MSB of the DES-numbered vector).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit i set when key K(i+1) uses a two-position shift.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) begin
      r[55-j] = k[6'(64 - PC1_TAB[j])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      r[47-j] = cd[6'(56 - PC2_TAB[j])];
    end
    return r;
  endfunction

  // DES bit 1 of each half sits at index 27, so a DES left rotate moves
  // the top bit to the bottom.
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e      state_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q;
  logic        dir_q;
  logic        valid_q;
  logic        done_q;

  logic [55:0] pc1_key;
  logic        last_key;
  logic [3:0]  step_idx;
  logic        two_step;

  always_comb begin
    pc1_key  = pc1(i_key);
    last_key = dir_q ? (round_q == 4'd0) : (round_q == 4'd15);
    // Encrypt applies the shift of the next key; decrypt undoes the current one.
    step_idx = dir_q ? round_q : (round_q + 4'd1);
    two_step = SHIFT2[step_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_load) begin
        if (i_decrypt) begin
          c_q <= pc1_key[55:28];
          d_q <= pc1_key[27:0];
        end else begin
          c_q <= rotl(pc1_key[55:28], 1'b0);
          d_q <= rotl(pc1_key[27:0], 1'b0);
        end
        round_q <= i_decrypt ? 4'd15 : 4'd0;
        dir_q   <= i_decrypt;
        valid_q <= 1'b1;
        state_q <= S_ACTIVE;
      end else if (state_q == S_ACTIVE && valid_q && i_next) begin
        if (last_key) begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else if (dir_q) begin
          c_q     <= rotr(c_q, two_step);
          d_q     <= rotr(d_q, two_step);
          round_q <= round_q - 4'd1;
        end else begin
          c_q     <= rotl(c_q, two_step);
          d_q     <= rotl(d_q, two_step);
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  assign o_round_key = pc2({c_q, d_q});
  assign o_round     = round_q;
  assign o_valid     = valid_q;
  assign o_done      = done_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: a textbook DES key-expansion model predicts every
// output each cycle, with directed scenarios and literal FIPS key values.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PARITY = 64'h0101010101010101;
  localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst, load, dec, nxt;
  logic [63:0] key;
  logic [47:0] o_round_key;
  logic [3:0]  o_round;
  logic        o_valid, o_done, o_state;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_key(key), .i_decrypt(dec),
    .i_next(nxt), .o_round_key(o_round_key), .o_round(o_round),
    .o_valid(o_valid), .o_done(o_done), .o_state(o_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Straight FIPS 46-3 expansion: cumulative left shifts from PC-1, then PC-2.
  function automatic logic [767:0] des_keys(input logic [63:0] k);
    logic kb [1:64];
    logic c [1:28];
    logic d [1:28];
    logic cd [1:56];
    logic tc, td;
    logic [767:0] r;
    r = '0;
    for (int i = 1; i <= 64; i++) kb[i] = k[64-i];
    for (int j = 0; j < 28; j++) begin
      c[j+1] = kb[PC1[j]];
      d[j+1] = kb[PC1[j+28]];
    end
    for (int rr = 1; rr <= 16; rr++) begin
      for (int s = 0; s < SHIFTS[rr-1]; s++) begin
        tc = c[1];
        td = d[1];
        for (int i = 1; i < 28; i++) begin
          c[i] = c[i+1];
          d[i] = d[i+1];
        end
        c[28] = tc;
        d[28] = td;
      end
      for (int i = 1; i <= 28; i++) begin
        cd[i]    = c[i];
        cd[i+28] = d[i];
      end
      for (int b = 1; b <= 48; b++) r[(rr-1)*48 + (48-b)] = cd[PC2[b-1]];
    end
    return r;
  endfunction

  logic [767:0] m_ks    = '0;
  int           m_round = 0;
  logic         m_valid = 1'b0;
  logic         m_done  = 1'b0;
  logic         m_dir   = 1'b0;
  logic         m_zero  = 1'b1;
  logic         chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_round = 0; m_valid = 1'b0; m_done = 1'b0; m_dir = 1'b0; m_zero = 1'b1;
    end else if (load) begin
      m_ks    = des_keys(key);
      m_round = dec ? 15 : 0;
      m_dir   = dec;
      m_valid = 1'b1;
      m_done  = 1'b0;
      m_zero  = 1'b0;
    end else if (m_valid && nxt) begin
      m_done = 1'b0;
      if ((m_dir && m_round == 0) || (!m_dir && m_round == 15)) begin
        m_valid = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_round = m_dir ? m_round - 1 : m_round + 1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {63'd0, o_valid}, {63'd0, m_valid});
      chk("done", {63'd0, o_done}, {63'd0, m_done});
      chk("round", {60'd0, o_round}, 64'(m_round));
      chk("key", {16'd0, o_round_key}, m_zero ? 64'd0 : {16'd0, m_ks[m_round*48 +: 48]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [63:0] k, input logic d);
    load = 1'b1; key = k; dec = d;
    cycle();
    load = 1'b0;
  endtask

  logic [47:0] exp_q [$];
  logic [767:0] ks;
  int idx;
  logic n;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; dec = 1'b0; nxt = 1'b0; key = '0;

    // Pin the model to published values.
    ks = des_keys(KEY_A);
    chk("model_k1", {16'd0, ks[0 +: 48]}, {16'd0, K1_A});
    chk("model_k2", {16'd0, ks[48 +: 48]}, {16'd0, K2_A});
    chk("model_k16", {16'd0, ks[15*48 +: 48]}, {16'd0, K16_A});

    repeat (2) cycle();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_key", {16'd0, o_round_key}, 64'd0);
    chk("reset_valid", {63'd0, o_valid}, 64'd0);

    // Encrypt at full rate.
    do_load(KEY_A, 1'b0);
    chk("enc_k1", {16'd0, o_round_key}, {16'd0, K1_A});
    chk("enc_r0", {60'd0, o_round}, 64'd0);
    exp_q.push_back(o_round_key);
    nxt = 1'b1;
    cycle();
    chk("enc_k2", {16'd0, o_round_key}, {16'd0, K2_A});
    chk("enc_r1", {60'd0, o_round}, 64'd1);
    exp_q.push_back(o_round_key);
    repeat (14) begin
      cycle();
      exp_q.push_back(o_round_key);
    end
    chk("enc_k16", {16'd0, o_round_key}, {16'd0, K16_A});
    chk("enc_r15", {60'd0, o_round}, 64'd15);
    cycle();
    chk("enc_done", {63'd0, o_done}, 64'd1);
    chk("enc_valid_low", {63'd0, o_valid}, 64'd0);
    nxt = 1'b0;
    cycle();
    chk("enc_done_clear", {63'd0, o_done}, 64'd0);

    // i_next in IDLE changes nothing.
    nxt = 1'b1;
    repeat (3) begin
      cycle();
      chk("idle_key_hold", {16'd0, o_round_key}, {16'd0, K16_A});
      chk("idle_round_hold", {60'd0, o_round}, 64'd15);
      chk("idle_no_done", {63'd0, o_done}, 64'd0);
    end
    nxt = 1'b0;

    // Decrypt: reverse of the encrypt capture; i_decrypt wiggles mid-schedule.
    do_load(KEY_A, 1'b1);
    chk("dec_k16", {16'd0, o_round_key}, {16'd0, K16_A});
    chk("dec_r15", {60'd0, o_round}, 64'd15);
    for (int i = 14; i >= 0; i--) begin
      nxt = 1'b1;
      dec = 1'($urandom_range(0, 1));
      cycle();
      chk("dec_reverse", {16'd0, o_round_key}, {16'd0, exp_q[i]});
    end
    chk("dec_k1", {16'd0, o_round_key}, {16'd0, K1_A});
    chk("dec_r0", {60'd0, o_round}, 64'd0);
    cycle();
    chk("dec_done", {63'd0, o_done}, 64'd1);
    nxt = 1'b0;
    cycle();

    // Parity bits ignored; i_next gapped randomly.
    do_load(KEY_A ^ PARITY, 1'b0);
    chk("par_k1", {16'd0, o_round_key}, {16'd0, exp_q[0]});
    idx = 0;
    for (int t = 0; t < 400 && idx < 16; t++) begin
      n = 1'($urandom_range(0, 1));
      nxt = n;
      cycle();
      if (n) idx++;
      if (idx < 16) begin
        chk("par_key", {16'd0, o_round_key}, {16'd0, exp_q[idx]});
        chk("par_round", {60'd0, o_round}, 64'(idx));
      end else begin
        chk("par_done", {63'd0, o_done}, 64'd1);
      end
    end
    chk("par_finished", 64'(idx), 64'd16);
    nxt = 1'b0;
    cycle();

    // Restart mid-schedule with i_next also high.
    do_load(KEY_B, 1'b0);
    nxt = 1'b1;
    repeat (7) cycle();
    chk("rs_r7", {60'd0, o_round}, 64'd7);
    load = 1'b1; key = KEY_A; dec = 1'b0;
    cycle();
    load = 1'b0; nxt = 1'b0;
    chk("rs_k1", {16'd0, o_round_key}, {16'd0, K1_A});
    chk("rs_r0", {60'd0, o_round}, 64'd0);
    chk("rs_no_done", {63'd0, o_done}, 64'd0);
    chk("rs_valid", {63'd0, o_valid}, 64'd1);

    // Reset at round 9 overrides a simultaneous load and next.
    nxt = 1'b1;
    repeat (9) cycle();
    chk("rst_r9", {60'd0, o_round}, 64'd9);
    rst = 1'b1; load = 1'b1; key = KEY_B;
    cycle();
    rst = 1'b0; load = 1'b0; nxt = 1'b0;
    chk("rst_key", {16'd0, o_round_key}, 64'd0);
    chk("rst_round", {60'd0, o_round}, 64'd0);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    do_load(KEY_A, 1'b0);
    chk("post_rst_k1", {16'd0, o_round_key}, {16'd0, K1_A});
    nxt = 1'b1;
    cycle();
    chk("post_rst_k2", {16'd0, o_round_key}, {16'd0, K2_A});
    nxt = 1'b0;
    repeat (2) cycle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
